// File: rtl/pnr_pkg.sv
// Shared constants for the PNR configuration register bank: address map,
// reset defaults, event-number width and the INFO word layout.
package pnr_pkg;

    localparam int EVT_NUM_W = 4;

    localparam logic [19:0] ADDR_LED       = 20'h00000;
    localparam logic [19:0] ADDR_TRIG_SRC  = 20'h00004;
    localparam logic [19:0] ADDR_TRIG_THR  = 20'h00008;
    localparam logic [19:0] ADDR_CLEARANCE = 20'h0000C;
    localparam logic [19:0] ADDR_DELAY     = 20'h00010;
    localparam logic [19:0] ADDR_CTRL      = 20'h00014;
    localparam logic [19:0] ADDR_STATUS    = 20'h00018;
    localparam logic [19:0] ADDR_INFO      = 20'h0001C;
    localparam logic [19:0] ADDR_THR_BASE  = 20'h00040;
    localparam logic [19:0] ADDR_CNT_BASE  = 20'h00100;

    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    localparam logic        RST_TRIG_IS_ADC_A = 1'b1;
    localparam logic [31:0] RST_CLEARANCE     = 32'd200;
    localparam logic [31:0] RST_DELAY         = 32'd100;

    // INFO = {reserved, CNT_W, ADC_W, N_THR}, one byte each
    function automatic logic [31:0] info_word(input int n_thr, input int adc_w, input int cnt_w);
        return {8'h00, 8'(cnt_w), 8'(adc_w), 8'(n_thr)};
    endfunction

endpackage

// File: rtl/pnr_bin_counter.sv
// Saturating event counter for one photon-number bin; clear beats increment.
module pnr_bin_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pnr_config_regs.sv
// Shadow/active configuration bank with safe-point commit and per-photon-number
// counters. Define PNR_THR_MONOTONIC_CHECK_EN to reject non-monotonic thresholds.
module pnr_config_regs
    import pnr_pkg::*;
#(
    parameter int N_THR = 8,
    parameter int ADC_W = 14,
    parameter int CNT_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [31:0]            sys_addr,
    input  logic [31:0]            sys_wdata,
    input  logic                   sys_wen,
    input  logic                   sys_ren,
    output logic [31:0]            sys_rdata,
    output logic                   sys_err,
    output logic                   sys_ack,
    output logic [7:0]             led_o,
    output logic                   trig_is_adc_a_o,
    output logic [ADC_W-1:0]       trig_threshold_o,
    output logic [31:0]            trig_clearance_o,
    output logic [31:0]            pnr_delay_o,
    output logic [N_THR*ADC_W-1:0] thr_o,
    input  logic                   apply_ok_i,
    output logic                   commit_o,
    input  logic                   event_valid_i,
    input  logic [EVT_NUM_W-1:0]   event_num_i
);

    logic [19:0] offs;
    logic [3:0]  idx;
    logic        aligned;
    logic        unused_addr_bits;
    logic        sel_led, sel_src, sel_tthr, sel_clr, sel_dly;
    logic        sel_ctrl, sel_status, sel_info, sel_thr, sel_cnt;
    logic        wr_ok, rd_ok, wr_en, commit_req, clear_req;
    logic        do_apply, mono_ok, commit_fire;
    logic [31:0] rd_mux;

    logic [7:0]       led_reg;
    logic             src_sh_reg, src_act_reg;
    logic [ADC_W-1:0] tthr_sh_reg, tthr_act_reg;
    logic [31:0]      clr_sh_reg, clr_act_reg;
    logic [31:0]      dly_sh_reg, dly_act_reg;
    logic [ADC_W-1:0] thr_sh_reg  [N_THR];
    logic [ADC_W-1:0] thr_act_reg [N_THR];
    logic             pending_reg, rejected_reg, commit_reg;
    logic             ack_reg, err_reg;
    logic [31:0]      rdata_reg;
    logic [CNT_W-1:0] cnt [N_THR+1];

    assign offs             = sys_addr[19:0];
    assign idx              = offs[5:2];
    assign aligned          = (offs[1:0] == 2'b00);
    assign unused_addr_bits = ^sys_addr[31:20];

    assign sel_led    = (offs == ADDR_LED);
    assign sel_src    = (offs == ADDR_TRIG_SRC);
    assign sel_tthr   = (offs == ADDR_TRIG_THR);
    assign sel_clr    = (offs == ADDR_CLEARANCE);
    assign sel_dly    = (offs == ADDR_DELAY);
    assign sel_ctrl   = (offs == ADDR_CTRL);
    assign sel_status = (offs == ADDR_STATUS);
    assign sel_info   = (offs == ADDR_INFO);
    assign sel_thr    = (offs[19:6] == ADDR_THR_BASE[19:6]) && aligned && (idx < 4'(N_THR));
    assign sel_cnt    = (offs[19:6] == ADDR_CNT_BASE[19:6]) && aligned && (idx <= 4'(N_THR));

    assign wr_ok      = sel_led | sel_src | sel_tthr | sel_clr | sel_dly | sel_ctrl | sel_thr;
    assign rd_ok      = sel_led | sel_src | sel_tthr | sel_clr | sel_dly | sel_status
                      | sel_info | sel_thr | sel_cnt;
    assign wr_en      = sys_wen && wr_ok;
    assign commit_req = wr_en && sel_ctrl && sys_wdata[CTRL_COMMIT_BIT];
    assign clear_req  = wr_en && sel_ctrl && sys_wdata[CTRL_CLEAR_BIT];

`ifdef PNR_THR_MONOTONIC_CHECK_EN
    always_comb begin
        mono_ok = 1'b1;
        for (int k = 0; k < N_THR - 1; k++) begin
            if (thr_sh_reg[k] > thr_sh_reg[k+1]) mono_ok = 1'b0;
        end
    end
`else
    assign mono_ok = 1'b1;
`endif

    assign do_apply    = pending_reg && apply_ok_i;
    assign commit_fire = do_apply && mono_ok;

    always_comb begin
        rd_mux = '0;
        if (sel_led)    rd_mux[7:0]       = led_reg;
        if (sel_src)    rd_mux[0]         = src_sh_reg;
        if (sel_tthr)   rd_mux[ADC_W-1:0] = tthr_sh_reg;
        if (sel_clr)    rd_mux            = clr_sh_reg;
        if (sel_dly)    rd_mux            = dly_sh_reg;
        if (sel_status) rd_mux[1:0]       = {rejected_reg, pending_reg};
        if (sel_info)   rd_mux            = info_word(N_THR, ADC_W, CNT_W);
        for (int k = 0; k < N_THR; k++) begin
            if (sel_thr && (idx == 4'(k))) rd_mux[ADC_W-1:0] = thr_sh_reg[k];
        end
        for (int b = 0; b <= N_THR; b++) begin
            if (sel_cnt && (idx == 4'(b))) rd_mux[CNT_W-1:0] = cnt[b];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            led_reg      <= '0;
            src_sh_reg   <= RST_TRIG_IS_ADC_A;
            src_act_reg  <= RST_TRIG_IS_ADC_A;
            tthr_sh_reg  <= '0;
            tthr_act_reg <= '0;
            clr_sh_reg   <= RST_CLEARANCE;
            clr_act_reg  <= RST_CLEARANCE;
            dly_sh_reg   <= RST_DELAY;
            dly_act_reg  <= RST_DELAY;
            for (int k = 0; k < N_THR; k++) begin
                thr_sh_reg[k]  <= '0;
                thr_act_reg[k] <= '0;
            end
            pending_reg  <= 1'b0;
            rejected_reg <= 1'b0;
            commit_reg   <= 1'b0;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
            rdata_reg    <= '0;
        end else begin
            ack_reg    <= sys_wen | sys_ren;
            err_reg    <= (sys_wen && !wr_ok) || (sys_ren && !rd_ok);
            rdata_reg  <= rd_mux;
            commit_reg <= commit_fire;

            // A commit request in the copy cycle re-arms pending for the next safe point
            if (commit_req)    pending_reg <= 1'b1;
            else if (do_apply) pending_reg <= 1'b0;
            if (do_apply)      rejected_reg <= !mono_ok;

            if (commit_fire) begin
                src_act_reg  <= src_sh_reg;
                tthr_act_reg <= tthr_sh_reg;
                clr_act_reg  <= clr_sh_reg;
                dly_act_reg  <= dly_sh_reg;
                for (int k = 0; k < N_THR; k++) thr_act_reg[k] <= thr_sh_reg[k];
            end

            if (wr_en) begin
                if (sel_led)  led_reg     <= sys_wdata[7:0];
                if (sel_src)  src_sh_reg  <= sys_wdata[0];
                if (sel_tthr) tthr_sh_reg <= sys_wdata[ADC_W-1:0];
                if (sel_clr)  clr_sh_reg  <= sys_wdata;
                if (sel_dly)  dly_sh_reg  <= sys_wdata;
                for (int k = 0; k < N_THR; k++) begin
                    if (sel_thr && (idx == 4'(k))) thr_sh_reg[k] <= sys_wdata[ADC_W-1:0];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi <= N_THR; gi++) begin : g_bin
            pnr_bin_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .inc   (event_valid_i && (event_num_i == EVT_NUM_W'(gi))),
                .clr   (clear_req),
                .count (cnt[gi])
            );
        end
        for (gi = 0; gi < N_THR; gi++) begin : g_thr_o
            assign thr_o[gi*ADC_W +: ADC_W] = thr_act_reg[gi];
        end
    endgenerate

    assign sys_rdata        = rdata_reg;
    assign sys_err          = err_reg;
    assign sys_ack          = ack_reg;
    assign led_o            = led_reg;
    assign trig_is_adc_a_o  = src_act_reg;
    assign trig_threshold_o = tthr_act_reg;
    assign trig_clearance_o = clr_act_reg;
    assign pnr_delay_o      = dly_act_reg;
    assign commit_o         = commit_reg;

endmodule

// File: tb/tb_pnr_config_regs.sv
// Randomised bench for pnr_config_regs against a transaction-level register model;
// a second small instance (N_THR=3, CNT_W=4) covers counter saturation.
module tb_pnr_config_regs;

    localparam int N_THR = 8;
    localparam int ADC_W = 14;
    localparam int CNT_W = 32;
    localparam int S_N_THR = 3;
    localparam int S_CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] sys_addr = '0, sys_wdata = '0, sys_rdata;
    logic sys_wen = 1'b0, sys_ren = 1'b0, sys_err, sys_ack;
    logic [7:0] led_o;
    logic trig_is_adc_a_o;
    logic [ADC_W-1:0] trig_threshold_o;
    logic [31:0] trig_clearance_o, pnr_delay_o;
    logic [N_THR*ADC_W-1:0] thr_o;
    logic apply_ok = 1'b0, commit_o;
    logic event_valid = 1'b0;
    logic [3:0] event_num = '0;

    logic [31:0] s_addr = '0, s_rdata;
    logic s_ren = 1'b0, s_err, s_ack, s_adc_a, s_commit;
    logic [7:0] s_led;
    logic [ADC_W-1:0] s_tthr;
    logic [31:0] s_clr, s_dly;
    logic [S_N_THR*ADC_W-1:0] s_thr;
    logic s_event_valid = 1'b0;
    logic [3:0] s_event_num = '0;

    pnr_config_regs #(.N_THR(N_THR), .ADC_W(ADC_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .sys_addr(sys_addr), .sys_wdata(sys_wdata),
        .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(sys_rdata), .sys_err(sys_err),
        .sys_ack(sys_ack), .led_o(led_o), .trig_is_adc_a_o(trig_is_adc_a_o),
        .trig_threshold_o(trig_threshold_o), .trig_clearance_o(trig_clearance_o),
        .pnr_delay_o(pnr_delay_o), .thr_o(thr_o), .apply_ok_i(apply_ok),
        .commit_o(commit_o), .event_valid_i(event_valid), .event_num_i(event_num)
    );

    pnr_config_regs #(.N_THR(S_N_THR), .ADC_W(ADC_W), .CNT_W(S_CNT_W)) dut_small (
        .clk_i(clk), .rst_i(rst), .sys_addr(s_addr), .sys_wdata(32'h0),
        .sys_wen(1'b0), .sys_ren(s_ren), .sys_rdata(s_rdata), .sys_err(s_err),
        .sys_ack(s_ack), .led_o(s_led), .trig_is_adc_a_o(s_adc_a),
        .trig_threshold_o(s_tthr), .trig_clearance_o(s_clr),
        .pnr_delay_o(s_dly), .thr_o(s_thr), .apply_ok_i(1'b0),
        .commit_o(s_commit), .event_valid_i(s_event_valid), .event_num_i(s_event_num)
    );

    int total = 0;
    int bad = 0;
    int commit_seen = 0;
    always @(negedge clk) if (commit_o === 1'b1) commit_seen++;

    // Behavioural register model
    logic [7:0]       m_led;
    logic             m_src_sh, m_src_act;
    logic [ADC_W-1:0] m_tthr_sh, m_tthr_act;
    logic [31:0]      m_clr_sh, m_clr_act, m_dly_sh, m_dly_act;
    logic [ADC_W-1:0] m_thr_sh [N_THR];
    logic [ADC_W-1:0] m_thr_act [N_THR];
    logic             m_pending, m_rejected;
    longint           m_cnt [N_THR+1];
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    task automatic model_reset();
        m_led = 0; m_src_sh = 1; m_src_act = 1; m_tthr_sh = 0; m_tthr_act = 0;
        m_clr_sh = 200; m_clr_act = 200; m_dly_sh = 100; m_dly_act = 100;
        for (int k = 0; k < N_THR; k++) begin m_thr_sh[k] = 0; m_thr_act[k] = 0; end
        m_pending = 0; m_rejected = 0;
        for (int b = 0; b <= N_THR; b++) m_cnt[b] = 0;
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        int o;
        o = int'(a[19:0]);
        if (o == 'h00) m_led = d[7:0];
        else if (o == 'h04) m_src_sh = d[0];
        else if (o == 'h08) m_tthr_sh = d[ADC_W-1:0];
        else if (o == 'h0C) m_clr_sh = d;
        else if (o == 'h10) m_dly_sh = d;
        else if (o == 'h14) begin
            if (d[0]) m_pending = 1;
            if (d[1]) for (int b = 0; b <= N_THR; b++) m_cnt[b] = 0;
        end else if (o >= 'h40 && o < 'h40 + 4 * N_THR && o % 4 == 0)
            m_thr_sh[(o - 'h40) / 4] = d[ADC_W-1:0];
    endtask

    task automatic model_apply();
        bit ok;
        ok = 1;
`ifdef PNR_THR_MONOTONIC_CHECK_EN
        for (int k = 0; k < N_THR - 1; k++) if (m_thr_sh[k] > m_thr_sh[k+1]) ok = 0;
`endif
        m_pending = 0;
        m_rejected = !ok;
        if (ok) begin
            m_src_act = m_src_sh; m_tthr_act = m_tthr_sh; m_clr_act = m_clr_sh; m_dly_act = m_dly_sh;
            for (int k = 0; k < N_THR; k++) m_thr_act[k] = m_thr_sh[k];
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int o;
        o = int'(a[19:0]);
        if (o == 'h00) return {24'h0, m_led};
        if (o == 'h04) return {31'h0, m_src_sh};
        if (o == 'h08) return 32'(m_tthr_sh);
        if (o == 'h0C) return m_clr_sh;
        if (o == 'h10) return m_dly_sh;
        if (o == 'h18) return {30'h0, m_rejected, m_pending};
        if (o == 'h1C) return {8'h0, 8'(CNT_W), 8'(ADC_W), 8'(N_THR)};
        if (o >= 'h40 && o < 'h40 + 4 * N_THR && o % 4 == 0) return 32'(m_thr_sh[(o - 'h40) / 4]);
        if (o >= 'h100 && o <= 'h100 + 4 * N_THR && o % 4 == 0) return 32'(m_cnt[(o - 'h100) / 4]);
        return 32'h0;
    endfunction

    function automatic logic [N_THR*ADC_W-1:0] thr_pack();
        logic [N_THR*ADC_W-1:0] v;
        v = '0;
        for (int k = 0; k < N_THR; k++) v[k*ADC_W +: ADC_W] = m_thr_act[k];
        return v;
    endfunction

    // Bus tasks: entered and left on a falling edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output logic err, output logic ack);
        sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
        @(negedge clk);
        sys_wen = 1'b0;
        err = sys_err; ack = sys_ack;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic err, output logic ack);
        sys_addr = a; sys_ren = 1'b1;
        @(negedge clk);
        sys_ren = 1'b0;
        d = sys_rdata; err = sys_err; ack = sys_ack;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        logic e, k;
        bus_write(a, d, e, k);
        model_write(a, d);
    endtask

    task automatic drive_event(input logic v, input logic [3:0] n);
        event_valid = v; event_num = n;
        @(negedge clk);
        event_valid = 1'b0;
        if (v && n <= N_THR && m_cnt[n] < CNT_MAX) m_cnt[n]++;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic e, k;
        logic [31:0] addrs [4];
        rst = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        total++; if (sys_ack !== 1'b0 || sys_err !== 1'b0 || commit_o !== 1'b0) begin bad++; $display("FAIL reset_flags: ack=%b err=%b commit=%b expected 0", sys_ack, sys_err, commit_o); end
        total++; if (sys_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h expected 0", sys_rdata); end
        total++; if (thr_o !== '0 || led_o !== 8'h0) begin bad++; $display("FAIL reset_thr_led: thr=%h led=%h expected 0", thr_o, led_o); end
        total++; if (trig_is_adc_a_o !== 1'b1 || trig_threshold_o !== '0 || trig_clearance_o !== 32'd200 || pnr_delay_o !== 32'd100) begin bad++; $display("FAIL reset_active: src=%b thr=%0d clr=%0d dly=%0d expected 1 0 200 100", trig_is_adc_a_o, trig_threshold_o, trig_clearance_o, pnr_delay_o); end
        rst = 1'b0;
        addrs = '{32'h0C, 32'h10, 32'h04, 32'h1C};
        for (int i = 0; i < 4; i++) begin
            bus_read(addrs[i], d, e, k);
            total++; if (d !== model_read(addrs[i]) || k !== 1'b1 || e !== 1'b0) begin bad++; $display("FAIL reset_read %h: got %h ack=%b err=%b expected %h ack=1 err=0", addrs[i], d, k, e, model_read(addrs[i])); end
        end
        @(negedge clk);
        total++; if (sys_ack !== 1'b0) begin bad++; $display("FAIL ack_single: got %b expected 0", sys_ack); end
    endtask

    task automatic test_shadow_rw();
        logic [31:0] a, d, q;
        logic e, k;
        int r;
        apply_ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            r = $urandom_range(0, 4 + N_THR);
            a = (r < 5) ? 32'(r * 4) : 32'('h40 + 4 * (r - 5));
            d = $urandom;
            do_write(a, d);
            bus_read(a, q, e, k);
            total++; if (q !== model_read(a) || e !== 1'b0) begin bad++; $display("FAIL shadow_rw %h: got %h err=%b expected %h", a, q, e, model_read(a)); end
        end
        total++; if (led_o !== m_led) begin bad++; $display("FAIL led_direct: got %h expected %h", led_o, m_led); end
        total++; if (thr_o !== thr_pack() || trig_clearance_o !== m_clr_act || pnr_delay_o !== m_dly_act || trig_threshold_o !== m_tthr_act || trig_is_adc_a_o !== m_src_act) begin bad++; $display("FAIL shadow_isolated: thr=%h clr=%0d expected thr=%h clr=%0d", thr_o, trig_clearance_o, thr_pack(), m_clr_act); end
    endtask

    task automatic test_commit();
        logic [31:0] q, newclr;
        logic e, k;
        int c0;
        apply_ok = 1'b0;
        do_write(32'h40, 32'h0);
        for (int i = 2; i < N_THR; i++) do_write(32'('h40 + 4 * i), 32'(i * 'h700));
        do_write(32'h44, 32'h0123);
        do_write(32'h14, 32'h1);
        bus_read(32'h44, q, e, k);
        total++; if (q !== 32'h0123) begin bad++; $display("FAIL commit_shadow_rb: got %h expected 00000123", q); end
        bus_read(32'h18, q, e, k);
        total++; if (q !== model_read(32'h18)) begin bad++; $display("FAIL commit_pending: got %h expected %h", q, model_read(32'h18)); end
        c0 = commit_seen;
        repeat (5) @(negedge clk);
        total++; if (commit_seen != c0 || thr_o[ADC_W +: ADC_W] !== m_thr_act[1]) begin bad++; $display("FAIL commit_held: pulses=%0d slice1=%h expected 0 %h", commit_seen - c0, thr_o[ADC_W +: ADC_W], m_thr_act[1]); end
        apply_ok = 1'b1;
        repeat (4) @(negedge clk);
        model_apply();
        total++; if (commit_seen - c0 != 1) begin bad++; $display("FAIL commit_pulses: got %0d expected 1", commit_seen - c0); end
        total++; if (thr_o !== thr_pack() || trig_clearance_o !== m_clr_act || pnr_delay_o !== m_dly_act || trig_is_adc_a_o !== m_src_act || trig_threshold_o !== m_tthr_act) begin bad++; $display("FAIL commit_active: thr=%h expected %h", thr_o, thr_pack()); end
        bus_read(32'h18, q, e, k);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL commit_status: got %h expected 0", q); end
        // minimum latency with apply_ok already high
        newclr = $urandom;
        do_write(32'h0C, newclr);
        sys_addr = 32'h14; sys_wdata = 32'h1; sys_wen = 1'b1;
        @(negedge clk);
        sys_wen = 1'b0;
        total++; if (commit_o !== 1'b0 || trig_clearance_o !== m_clr_act) begin bad++; $display("FAIL latency_early: commit=%b clr=%h expected 0 %h", commit_o, trig_clearance_o, m_clr_act); end
        @(negedge clk);
        model_apply();
        total++; if (commit_o !== 1'b1 || trig_clearance_o !== newclr) begin bad++; $display("FAIL latency_apply: commit=%b clr=%h expected 1 %h", commit_o, trig_clearance_o, newclr); end
        apply_ok = 1'b0;
        @(negedge clk);
        total++; if (commit_o !== 1'b0) begin bad++; $display("FAIL commit_one_cycle: got %b expected 0", commit_o); end
    endtask

    task automatic test_copy_cycle();
        logic [31:0] q, va, vb, vc;
        logic e, k;
        va = $urandom_range(0, 'h122); vb = $urandom_range(0, 'h122); vc = $urandom_range(0, 'h122);
        apply_ok = 1'b0;
        do_write(32'h40, va);
        do_write(32'h14, 32'h1);
        sys_addr = 32'h40; sys_wdata = vb; sys_wen = 1'b1; apply_ok = 1'b1;
        @(negedge clk);
        sys_wen = 1'b0; apply_ok = 1'b0;
        model_apply(); model_write(32'h40, vb);
        total++; if (commit_o !== 1'b1 || thr_o[ADC_W-1:0] !== va[ADC_W-1:0]) begin bad++; $display("FAIL copy_pre_edge: commit=%b thr0=%h expected 1 %h", commit_o, thr_o[ADC_W-1:0], va[ADC_W-1:0]); end
        bus_read(32'h40, q, e, k);
        total++; if (q !== vb) begin bad++; $display("FAIL copy_shadow_kept: got %h expected %h", q, vb); end
        do_write(32'h14, 32'h1);
        sys_addr = 32'h14; sys_wdata = 32'h1; sys_wen = 1'b1; apply_ok = 1'b1;
        @(negedge clk);
        sys_wen = 1'b0; apply_ok = 1'b0;
        model_apply(); model_write(32'h14, 32'h1);
        total++; if (commit_o !== 1'b1 || thr_o !== thr_pack()) begin bad++; $display("FAIL copy_commit_wr: commit=%b thr=%h expected 1 %h", commit_o, thr_o, thr_pack()); end
        bus_read(32'h18, q, e, k);
        total++; if (q !== 32'h1) begin bad++; $display("FAIL copy_rearm: status=%h expected 1", q); end
        do_write(32'h40, vc);
        apply_ok = 1'b1;
        @(negedge clk);
        apply_ok = 1'b0;
        model_apply();
        total++; if (commit_o !== 1'b1 || thr_o[ADC_W-1:0] !== vc[ADC_W-1:0]) begin bad++; $display("FAIL copy_next: commit=%b thr0=%h expected 1 %h", commit_o, thr_o[ADC_W-1:0], vc[ADC_W-1:0]); end
    endtask

    task automatic test_counters();
        logic [31:0] q;
        logic e, k;
        do_write(32'h14, 32'h2);
        for (int i = 0; i < 5; i++) drive_event(1'b1, 4'd2);
        drive_event(1'b1, 4'(N_THR + 1));
        for (int b = 0; b <= N_THR; b++) begin
            bus_read(32'('h100 + 4 * b), q, e, k);
            total++; if (q !== model_read(32'('h100 + 4 * b))) begin bad++; $display("FAIL cnt_directed bin%0d: got %0d expected %0d", b, q, model_read(32'('h100 + 4 * b))); end
        end
        for (int i = 0; i < 60; i++) drive_event(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        for (int b = 0; b <= N_THR; b++) begin
            bus_read(32'('h100 + 4 * b), q, e, k);
            total++; if (q !== model_read(32'('h100 + 4 * b)) || e !== 1'b0) begin bad++; $display("FAIL cnt_random bin%0d: got %0d err=%b expected %0d", b, q, e, model_read(32'('h100 + 4 * b))); end
        end
        sys_addr = 32'h14; sys_wdata = 32'h2; sys_wen = 1'b1; event_valid = 1'b1; event_num = 4'd3;
        @(negedge clk);
        sys_wen = 1'b0; event_valid = 1'b0;
        model_write(32'h14, 32'h2);
        for (int b = 0; b <= N_THR; b++) begin
            bus_read(32'('h100 + 4 * b), q, e, k);
            total++; if (q !== 32'h0) begin bad++; $display("FAIL cnt_clear bin%0d: got %0d expected 0", b, q); end
        end
    endtask

    task automatic test_errors();
        logic [31:0] ea [10];
        bit ew [10];
        bit ee [10];
        logic [31:0] q;
        logic e, k;
        drive_event(1'b1, 4'd0);
        ea = '{32'h200, 32'h1C, 32'h14, 32'h18, 32'('h40 + 4 * N_THR), 32'('h100 + 4 * (N_THR + 1)), 32'h100, 32'h06, 32'h4010000C, 32'('h100 + 4 * N_THR)};
        ew = '{0, 1, 0, 1, 1, 0, 1, 0, 0, 0};
        ee = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        for (int i = 0; i < 10; i++) begin
            if (ew[i]) bus_write(ea[i], $urandom, e, k);
            else bus_read(ea[i], q, e, k);
            total++; if (e !== 1'(ee[i]) || k !== 1'b1) begin bad++; $display("FAIL bus_err %h wen=%0d: err=%b ack=%b expected err=%0d ack=1", ea[i], ew[i], e, k, ee[i]); end
            if (!ew[i]) begin
                total++; if (q !== model_read(ea[i])) begin bad++; $display("FAIL err_rdata %h: got %h expected %h", ea[i], q, model_read(ea[i])); end
            end
        end
        bus_read(32'h1C, q, e, k);
        total++; if (q !== model_read(32'h1C)) begin bad++; $display("FAIL info_unchanged: got %h expected %h", q, model_read(32'h1C)); end
        bus_read(32'h100, q, e, k);
        total++; if (q !== model_read(32'h100)) begin bad++; $display("FAIL ro_cnt_unchanged: got %h expected %h", q, model_read(32'h100)); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        addrs = '{32'h0C, 32'h10, 32'h00, 32'h1C};
        for (int i = 0; i < 4; i++) begin
            sys_addr = addrs[i]; sys_ren = 1'b1;
            @(negedge clk);
            total++; if (sys_ack !== 1'b1 || sys_rdata !== model_read(addrs[i])) begin bad++; $display("FAIL b2b_read %h: ack=%b got %h expected ack=1 %h", addrs[i], sys_ack, sys_rdata, model_read(addrs[i])); end
        end
        sys_ren = 1'b0;
        @(negedge clk);
        total++; if (sys_ack !== 1'b0) begin bad++; $display("FAIL b2b_ack_drop: got %b expected 0", sys_ack); end
    endtask

    task automatic test_monotonic();
        logic [31:0] q;
        logic e, k;
        int c0;
        apply_ok = 1'b0;
        do_write(32'h40, 32'h100);
        do_write(32'h44, 32'h080);
        for (int i = 2; i < N_THR; i++) do_write(32'('h40 + 4 * i), 32'h3FFF);
        c0 = commit_seen;
        apply_ok = 1'b1;
        do_write(32'h14, 32'h1);
        repeat (3) @(negedge clk);
        apply_ok = 1'b0;
        model_apply();
`ifdef PNR_THR_MONOTONIC_CHECK_EN
        total++; if (commit_seen != c0) begin bad++; $display("FAIL mono_reject_pulse: got %0d expected 0", commit_seen - c0); end
`else
        total++; if (commit_seen - c0 != 1) begin bad++; $display("FAIL mono_nocheck_pulse: got %0d expected 1", commit_seen - c0); end
`endif
        bus_read(32'h18, q, e, k);
        total++; if (q !== model_read(32'h18)) begin bad++; $display("FAIL mono_status: got %h expected %h", q, model_read(32'h18)); end
        total++; if (thr_o !== thr_pack()) begin bad++; $display("FAIL mono_active: got %h expected %h", thr_o, thr_pack()); end
        do_write(32'h40, 32'h080);
        do_write(32'h44, 32'h100);
        c0 = commit_seen;
        apply_ok = 1'b1;
        do_write(32'h14, 32'h1);
        repeat (3) @(negedge clk);
        apply_ok = 1'b0;
        model_apply();
        total++; if (commit_seen - c0 != 1 || thr_o !== thr_pack()) begin bad++; $display("FAIL mono_fixed: pulses=%0d thr=%h expected 1 %h", commit_seen - c0, thr_o, thr_pack()); end
        bus_read(32'h18, q, e, k);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL mono_status_clear: got %h expected 0", q); end
    endtask

    task automatic test_reset_mid_commit();
        logic [31:0] q;
        logic e, k;
        int c0;
        apply_ok = 1'b0;
        do_write(32'h0C, 32'd123);
        do_write(32'h14, 32'h1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        bus_read(32'h18, q, e, k);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL rst_pending: status=%h expected 0", q); end
        bus_read(32'h0C, q, e, k);
        total++; if (q !== 32'd200) begin bad++; $display("FAIL rst_shadow: got %0d expected 200", q); end
        c0 = commit_seen;
        apply_ok = 1'b1;
        repeat (3) @(negedge clk);
        apply_ok = 1'b0;
        total++; if (commit_seen != c0 || trig_clearance_o !== 32'd200) begin bad++; $display("FAIL rst_no_commit: pulses=%0d clr=%0d expected 0 200", commit_seen - c0, trig_clearance_o); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            s_event_valid = 1'b1; s_event_num = 4'd0;
            @(negedge clk);
        end
        s_event_num = 4'(S_N_THR + 1);
        @(negedge clk);
        s_event_valid = 1'b0;
        for (int b = 0; b <= S_N_THR; b++) begin
            s_addr = 32'('h100 + 4 * b); s_ren = 1'b1;
            @(negedge clk);
            s_ren = 1'b0;
            total++; if (s_rdata !== ((b == 0) ? 32'd15 : 32'd0) || s_err !== 1'b0) begin bad++; $display("FAIL sat_bin%0d: got %0d err=%b expected %0d", b, s_rdata, s_err, (b == 0) ? 15 : 0); end
        end
        s_addr = 32'h1C; s_ren = 1'b1;
        @(negedge clk);
        s_ren = 1'b0;
        total++; if (s_rdata !== {8'h0, 8'(S_CNT_W), 8'(ADC_W), 8'(S_N_THR)}) begin bad++; $display("FAIL small_info: got %h", s_rdata); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_shadow_rw();
        test_commit();
        test_copy_cycle();
        test_counters();
        test_errors();
        test_back_to_back();
        test_monotonic();
        test_reset_mid_commit();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
